// File: rtl/fpmult_round_pack_pkg.sv
// Shared definitions for the FP multiplier back end: default field widths,
// canonical special encodings and the result classification used when packing.
package fpmult_round_pack_pkg;

  localparam int EXP_W_DEF = 8;
  localparam int MAN_W_DEF = 23;
  localparam int BIAS_DEF  = 127;

  localparam logic [31:0] QNAN_DEF    = 32'h7FC0_0000;
  localparam logic [30:0] INF_MAG_DEF = 31'h7F80_0000;

  typedef enum logic [2:0] {
    RES_NAN,
    RES_INF,
    RES_ZERO,
    RES_OVF,
    RES_UNF,
    RES_NORM
  } res_kind_e;

endpackage

// File: rtl/fpmult_round_pack_if.sv
// Input beat and result bus of the FP multiplier back end, both valid/ready.
interface fpmult_round_pack_if
  import fpmult_round_pack_pkg::*;
#(
  parameter int EXP_W = EXP_W_DEF,
  parameter int MAN_W = MAN_W_DEF
);

  logic                   in_valid;
  logic                   in_ready;
  logic                   Sp;
  logic [EXP_W:0]         NormE;
  logic [MAN_W-1:0]       NormM;
  logic                   GRS;
  logic                   in_zero;
  logic                   in_inf;
  logic                   in_nan;
  logic                   out_valid;
  logic                   out_ready;
  logic [EXP_W+MAN_W:0]   P;
  logic                   ovf;
  logic                   unf;

  modport slave (
    input  in_valid, Sp, NormE, NormM, GRS, in_zero, in_inf, in_nan, out_ready,
    output in_ready, out_valid, P, ovf, unf
  );

  modport master (
    output in_valid, Sp, NormE, NormM, GRS, in_zero, in_inf, in_nan, out_ready,
    input  in_ready, out_valid, P, ovf, unf
  );

endinterface

// File: rtl/fpmult_round_inc.sv
// Combinational round and unbias: applies the upstream round-up decision to the
// mantissa and folds any rounding carry into the signed, unbiased exponent.
module fpmult_round_inc
  import fpmult_round_pack_pkg::*;
#(
  parameter int EXP_W = EXP_W_DEF,
  parameter int MAN_W = MAN_W_DEF,
  parameter int BIAS  = BIAS_DEF
) (
  input  logic [EXP_W:0]          norm_e,
  input  logic [MAN_W-1:0]        norm_m,
  input  logic                    grs,
  output logic [MAN_W-1:0]        man,
  output logic signed [EXP_W+1:0] es
);

  localparam int ESW = EXP_W + 2;
  localparam logic signed [ESW-1:0] BIAS_S = ESW'(BIAS);

  function automatic logic [MAN_W:0] round_man(input logic [MAN_W-1:0] m, input logic inc);
    return {1'b0, m} + {{MAN_W{1'b0}}, inc};
  endfunction

  logic [MAN_W:0]        mr;
  logic signed [ESW-1:0] e_ext;
  logic signed [ESW-1:0] carry_s;

  // A carry out of the mantissa wraps it to zero and bumps the exponent by one.
  always_comb begin
    mr      = round_man(norm_m, grs);
    e_ext   = $signed({1'b0, norm_e});
    carry_s = $signed({{(ESW-1){1'b0}}, mr[MAN_W]});
    man     = mr[MAN_W-1:0];
    es      = e_ext - BIAS_S + carry_s;
  end

endmodule

// File: rtl/fpmult_round_pack.sv
// FP multiplier back end: two-stage elastic pipeline that rounds, unbiases,
// range-checks and packs an IEEE-754 product with valid/ready on both sides.
module fpmult_round_pack
  import fpmult_round_pack_pkg::*;
#(
  parameter int EXP_W = EXP_W_DEF,
  parameter int MAN_W = MAN_W_DEF,
  parameter int BIAS  = BIAS_DEF
) (
  input logic               clk,
  input logic               rst,
  fpmult_round_pack_if.slave bus
);

  localparam int ESW = EXP_W + 2;
  localparam int W   = EXP_W + MAN_W + 1;
  localparam logic signed [ESW-1:0] ES_MAX = ESW'((2 ** EXP_W) - 1);
  localparam logic signed [ESW-1:0] ES_MIN = '0;
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  function automatic res_kind_e classify(input logic nan, input logic inf, input logic zero,
                                         input logic signed [ESW-1:0] es);
    if (nan)          return RES_NAN;
    if (inf)          return RES_INF;
    if (zero)         return RES_ZERO;
    if (es >= ES_MAX) return RES_OVF;
    if (es <= ES_MIN) return RES_UNF;
    return RES_NORM;
  endfunction

  // Returns {ovf, unf, packed word}; saturates to infinity or flushes to zero.
  function automatic logic [W+1:0] pack_result(input res_kind_e kind, input logic sign,
                                               input logic [EXP_W-1:0] exp_f,
                                               input logic [MAN_W-1:0] man);
    case (kind)
      RES_NAN:  return {2'b00, QNAN};
      RES_INF:  return {2'b00, sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      RES_ZERO: return {2'b00, sign, {(W-1){1'b0}}};
      RES_OVF:  return {2'b10, sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      RES_UNF:  return {2'b01, sign, {(W-1){1'b0}}};
      default:  return {2'b00, sign, exp_f, man};
    endcase
  endfunction

  logic                  vld_p1, vld_p2;
  logic                  rdy_p2, take_in, take_p2;
  logic [MAN_W-1:0]      man_rnd;
  logic signed [ESW-1:0] es_rnd;

  logic                  sign_p1, nan_p1, inf_p1, zero_p1;
  logic [MAN_W-1:0]      man_p1;
  logic signed [ESW-1:0] es_p1;
  logic [W+1:0]          result_p1;

  logic [W-1:0]          p_p2;
  logic                  ovf_p2, unf_p2;

  assign rdy_p2       = !vld_p2 || bus.out_ready;
  assign bus.in_ready = !vld_p1 || rdy_p2;
  assign take_in      = bus.in_valid && bus.in_ready;
  assign take_p2      = vld_p1 && rdy_p2;

  fpmult_round_inc #(
    .EXP_W (EXP_W),
    .MAN_W (MAN_W),
    .BIAS  (BIAS)
  ) u_round_inc (
    .norm_e (bus.NormE),
    .norm_m (bus.NormM),
    .grs    (bus.GRS),
    .man    (man_rnd),
    .es     (es_rnd)
  );

  // ---- stage 1: rounded mantissa, unbiased exponent and flags ----
  always_ff @(posedge clk) begin
    if (take_in) begin
      sign_p1 <= bus.Sp;
      man_p1  <= man_rnd;
      es_p1   <= es_rnd;
      nan_p1  <= bus.in_nan;
      inf_p1  <= bus.in_inf;
      zero_p1 <= bus.in_zero;
    end
  end

  always_comb begin
    result_p1 = pack_result(classify(nan_p1, inf_p1, zero_p1, es_p1),
                            sign_p1, es_p1[EXP_W-1:0], man_p1);
  end

  // ---- stage 2: packed result and range flags ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      p_p2   <= '0;
      ovf_p2 <= 1'b0;
      unf_p2 <= 1'b0;
    end else begin
      if (bus.in_ready) vld_p1 <= bus.in_valid;
      if (rdy_p2)       vld_p2 <= vld_p1;
      if (take_p2)      {ovf_p2, unf_p2, p_p2} <= result_p1;
    end
  end

  assign bus.out_valid = vld_p2;
  assign bus.P         = p_p2;
  assign bus.ovf       = ovf_p2;
  assign bus.unf       = unf_p2;

endmodule

// File: tb/tb_fpmult_round_pack.sv
// Bench for fpmult_round_pack: directed corner cases, stall/ordering, reset
// mid-stream, and randomized traffic checked against a value-level model.
module tb_fpmult_round_pack;
  import fpmult_round_pack_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fpmult_round_pack_if bus ();

  fpmult_round_pack dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          checks   = 0;
  int          failures = 0;
  logic [33:0] exp_q[$];
  bit          dir_mode = 1'b0;
  logic [33:0] dir_exp  = '0;
  bit          last_in_fire = 1'b0;
  int          outs = 0;

  task automatic check(input string tag, input logic [33:0] obs, input logic [33:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Value-level reference: {ovf, unf, packed word}.
  function automatic logic [33:0] model(input logic sp, input logic [8:0] ne, input logic [22:0] nm,
                                        input logic grs, input logic z, input logic inf,
                                        input logic nan);
    int m;
    int e;
    if (nan) return {2'b00, QNAN_DEF};
    if (inf) return {2'b00, sp, INF_MAG_DEF};
    if (z)   return {2'b00, sp, 31'd0};
    m = int'(nm) + int'(grs);
    e = int'(ne) - BIAS_DEF;
    if (m >= (1 << 23)) begin
      m = m - (1 << 23);
      e = e + 1;
    end
    if (e >= 255) return {2'b10, sp, INF_MAG_DEF};
    if (e <= 0)   return {2'b01, sp, 31'd0};
    return {2'b00, sp, e[7:0], m[22:0]};
  endfunction

  task automatic drive(input logic v, input logic sp, input logic [8:0] ne, input logic [22:0] nm,
                       input logic grs, input logic z, input logic inf, input logic nan);
    bus.in_valid = v;
    bus.Sp       = sp;
    bus.NormE    = ne;
    bus.NormM    = nm;
    bus.GRS      = grs;
    bus.in_zero  = z;
    bus.in_inf   = inf;
    bus.in_nan   = nan;
  endtask

  // One clock: observe transfers at the falling edge, then advance past the rising edge.
  task automatic step();
    @(negedge clk);
    last_in_fire = bus.in_valid && bus.in_ready;
    if (bus.out_valid && bus.out_ready) begin
      outs++;
      if (exp_q.size() == 0) check("spurious_out", 34'(exp_q.size()), 34'd1);
      else check("result", {bus.ovf, bus.unf, bus.P}, exp_q.pop_front());
    end
    if (last_in_fire)
      exp_q.push_back(dir_mode ? dir_exp :
                      model(bus.Sp, bus.NormE, bus.NormM, bus.GRS, bus.in_zero, bus.in_inf, bus.in_nan));
    @(posedge clk);
    #1;
  endtask

  // Single beat into an empty pipe with a fixed expected result and a 2-cycle latency check.
  task automatic single(input string tag, input logic sp, input logic [8:0] ne, input logic [22:0] nm,
                        input logic grs, input logic z, input logic inf, input logic nan,
                        input logic [33:0] expv);
    dir_mode = 1'b1;
    dir_exp  = expv;
    bus.out_ready = 1'b1;
    drive(1'b1, sp, ne, nm, grs, z, inf, nan);
    step();
    check({tag, "_accept"}, 34'(last_in_fire), 34'd1);
    bus.in_valid = 1'b0;
    @(negedge clk);
    check({tag, "_lat1"}, 34'(bus.out_valid), 34'd0);
    @(posedge clk);
    #1;
    step();
    check({tag, "_lat2"}, 34'(exp_q.size()), 34'd0);
    dir_mode = 1'b0;
  endtask

  logic [8:0]  ne_r;
  logic [22:0] nm_r;
  int          accepted;
  int          outs_mark;

  initial begin
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.out_ready = 1'b0;

    // Reset state.
    #12;
    check("rst_out_valid", 34'(bus.out_valid), 34'd0);
    check("rst_P", 34'(bus.P), 34'd0);
    check("rst_flags", 34'({bus.ovf, bus.unf}), 34'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_in_ready", 34'(bus.in_ready), 34'd1);

    // Directed results.
    single("mul_1p5", 1'b0, 9'd255, 23'h100000, 1'b0, 1'b0, 1'b0, 1'b0, {2'b00, 32'h4010_0000});
    single("carry",   1'b0, 9'd254, 23'h7FFFFF, 1'b1, 1'b0, 1'b0, 1'b0, {2'b00, 32'h4000_0000});
    single("ovf",     1'b1, 9'd400, 23'h000000, 1'b0, 1'b0, 1'b0, 1'b0, {2'b10, 32'hFF80_0000});
    single("unf",     1'b1, 9'd100, 23'h000000, 1'b0, 1'b0, 1'b0, 1'b0, {2'b01, 32'h8000_0000});
    single("nan_inf", 1'b1, 9'd300, 23'h123456, 1'b0, 1'b0, 1'b1, 1'b1, {2'b00, 32'h7FC0_0000});
    single("zero",    1'b1, 9'd50,  23'h000000, 1'b0, 1'b1, 1'b0, 1'b0, {2'b00, 32'h8000_0000});
    single("inf",     1'b0, 9'd10,  23'h000000, 1'b0, 1'b0, 1'b1, 1'b0, {2'b00, 32'h7F80_0000});
    single("min_norm",1'b0, 9'd128, 23'h000000, 1'b0, 1'b0, 1'b0, 1'b0, {2'b00, 32'h0080_0000});
    single("unf_edge",1'b0, 9'd127, 23'h000000, 1'b0, 1'b0, 1'b0, 1'b0, {2'b01, 32'h0000_0000});
    single("carry_up",1'b0, 9'd127, 23'h7FFFFF, 1'b1, 1'b0, 1'b0, 1'b0, {2'b00, 32'h0080_0000});
    single("max_norm",1'b0, 9'd381, 23'h7FFFFF, 1'b0, 1'b0, 1'b0, 1'b0, {2'b00, 32'h7F7F_FFFF});
    single("carry_ovf",1'b0,9'd381, 23'h7FFFFF, 1'b1, 1'b0, 1'b0, 1'b0, {2'b10, 32'h7F80_0000});

    // Back-pressure: four beats offered while the output is stalled.
    outs_mark = outs;
    accepted  = 0;
    bus.out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (accepted < 4) drive(1'b1, accepted[0], 9'(200 + accepted), 23'(accepted * 4099), 1'b0, 1'b0, 1'b0, 1'b0);
      else bus.in_valid = 1'b0;
      step();
      if (last_in_fire) accepted++;
    end
    check("stall_accepts", 34'(accepted), 34'd2);
    check("stall_in_ready", 34'(bus.in_ready), 34'd0);
    check("stall_out_valid", 34'(bus.out_valid), 34'd1);
    bus.out_ready = 1'b1;
    for (int c = 0; c < 20 && (accepted < 4 || exp_q.size() != 0); c++) begin
      if (accepted < 4) drive(1'b1, accepted[0], 9'(200 + accepted), 23'(accepted * 4099), 1'b0, 1'b0, 1'b0, 1'b0);
      else bus.in_valid = 1'b0;
      step();
      if (last_in_fire) accepted++;
    end
    bus.in_valid = 1'b0;
    check("stall_drained", 34'(exp_q.size()), 34'd0);
    check("stall_out_count", 34'(outs - outs_mark), 34'd4);

    // Reset with two beats in flight.
    bus.out_ready = 1'b0;
    drive(1'b1, 1'b0, 9'd255, 23'h100000, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    step();
    bus.in_valid = 1'b0;
    rst = 1'b0;
    #1;
    check("midrst_out_valid", 34'(bus.out_valid), 34'd0);
    check("midrst_P", 34'(bus.P), 34'd0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_in_ready", 34'(bus.in_ready), 34'd1);
    single("post_rst", 1'b1, 9'd255, 23'h100000, 1'b0, 1'b0, 1'b0, 1'b0, {2'b00, 32'hC010_0000});

    // Randomized traffic with random back-pressure.
    bus.in_valid = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!(bus.in_valid && !last_in_fire)) begin
        ne_r = ($urandom_range(0, 3) == 0) ? 9'($urandom_range(0, 511)) : 9'($urandom_range(110, 400));
        nm_r = ($urandom_range(0, 7) == 0) ? 23'h7FFFFF : 23'($urandom);
        drive(1'($urandom_range(0, 3) != 0), 1'($urandom), ne_r, nm_r, 1'($urandom),
              1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 15) == 0),
              1'($urandom_range(0, 15) == 0));
      end
      bus.out_ready = 1'($urandom_range(0, 9) < 7);
      step();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 10 && exp_q.size() != 0; c++) step();
    check("random_drained", 34'(exp_q.size()), 34'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
